icache_fetch: RTL and testbench

- Direct-mapped, read-only instruction cache between the PC/fetch stage and the memory arbiter.
- Answers each fetch address from the PC with a same-cycle hit, or stalls fetch while it fills one word from memory.
- It is the responder to the PC's fetch requests. The PC holds its address while `ihit` is low (`pcenable` is gated by `ihit`).

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/icache_frames.sv | 50 +++++
 rtl/icache_fetch.sv | 116 +++++++++++
 tb/tb_icache_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction-cache frame, address split and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ICACHE_SETS = 16;
  localparam int unsigned ICACHE_IDX  = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAGW = 30 - ICACHE_IDX;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDX-1:0]  idx;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef enum logic {IDLE, FILL} icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Valid/tag/data storage for the direct-mapped icache: one write port, one read port,
// synchronous clear-all of the valid bits. Only the valid bits are reset.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = ICACHE_SETS,
  parameter int unsigned TAGW = 30 - $clog2(ICACHE_SETS)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clr,
  input  logic                    we,
  input  logic [$clog2(SETS)-1:0] widx,
  input  logic                    wvalid,
  input  logic [TAGW-1:0]         wtag,
  input  word_t                   wdata,
  input  logic [$clog2(SETS)-1:0] ridx,
  output logic                    rvalid,
  output logic [TAGW-1:0]         rtag,
  output word_t                   rdata
);

  logic [SETS-1:0] valid_q, valid_d;
  logic [TAGW-1:0] tag_q  [SETS];
  word_t           data_q [SETS];

  // A write in the same cycle as a clear wins for its own frame (and carries wvalid).
  always_comb begin
    valid_d = valid_q;
    if (clr) valid_d = '0;
    if (we)  valid_d[widx] = wvalid;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-word fills on a miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = ICACHE_SETS
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  iinval,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDX;

  icache_state_t   state_q, state_d;
  word_t           miss_addr_q, miss_addr_d;
  logic            rd_valid, raw_hit, we;
  logic [TAGW-1:0] rd_tag;
  word_t           rd_data;
  logic            unused_bits;

  assign unused_bits = ^{imemaddr[1:0], miss_addr_q[1:0]};
  assign raw_hit = (state_q == IDLE) && imemREN && rd_valid && (rd_tag == imemaddr[31:IDX+2]);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    we          = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw_hit) begin
          // Invalidate suppresses the hit; the frame is gone next cycle anyway.
          ihit     = !iinval;
          imemload = iinval ? '0 : rd_data;
        end else if (imemREN) begin
          miss_addr_d = imemaddr;
          state_d     = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {miss_addr_q[31:2], 2'b00};
        if (!iwait) begin
          we      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  icache_frames #(
    .SETS (SETS),
    .TAGW (TAGW)
  ) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (iinval),
    .we     (we),
    .widx   (miss_addr_q[IDX+1:2]),
    .wvalid (!iinval),
    .wtag   (miss_addr_q[31:IDX+2]),
    .wdata  (iload),
    .ridx   (imemaddr[IDX+1:2]),
    .rvalid (rd_valid),
    .rtag   (rd_tag),
    .rdata  (rd_data)
  );

`ifdef ICACHE_STATS_EN
  word_t hit_count_q, miss_count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (ihit && (hit_count_q != '1)) hit_count_q <= hit_count_q + 32'd1;
      if ((state_q == IDLE) && (state_d == FILL) && (miss_count_q != '1))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: scenario tasks with a queue of expected fetch data.
module tb_icache_fetch;
  import cpu_types_pkg::*;

  logic  CLK, nRST, imemREN, ihit, iinval, iREN, iwait;
  word_t imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
  word_t hit_count, miss_count;
`endif

  int    checks = 0;
  int    errors = 0;
  word_t sb[$];

  icache_fetch dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iinval   (iinval),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t mem_word(input word_t a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Drives one fetch until ihit (bounded); answers FILL reads after `waits` busy cycles.
  task automatic fetch(input word_t a, input int waits, output int fills, output bit got,
                       output word_t data, output bit addr_bad);
    int w;
    w = waits; fills = 0; got = 0; data = '0; addr_bad = 0;
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK);
      if (ihit) begin
        got = 1; data = imemload;
      end else if (iREN) begin
        fills++;
        if (iaddr !== {a[31:2], 2'b00}) addr_bad = 1;
        if (w == 0) begin iwait = 1'b0; iload = mem_word(iaddr); end
        else w--;
      end
      @(posedge CLK); #1;
      iwait = 1'b1;
    end
    imemREN = 1'b0; iload = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iinval = 1'b0; iwait = 1'b1; iload = '0;
    #3;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got %b want 0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN got %b want 0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h want 0", iaddr); end
    checks++;
    if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload got %h want 0", imemload); end
    @(negedge CLK); nRST = 1'b1; imemREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_cold_miss();
    int fills; bit got, bad; word_t d, e;
    sb.push_back(mem_word(32'h40));
    fetch(32'h40, 3, fills, got, d, bad);
    checks++; if (fills !== 4) begin errors++; $display("FAIL cold_fill_cycles got %0d want 4", fills); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL cold_iaddr got bad want 0x40"); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL cold_data got %h hit %b want %h", d, got, e); end
  endtask

  task automatic test_hit();
    int fills; bit got, bad; word_t d, e;
    sb.push_back(mem_word(32'h40));
    fetch(32'h40, 0, fills, got, d, bad);
    checks++; if (fills !== 0) begin errors++; $display("FAIL hit_no_fill got %0d want 0", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL hit_data got %h hit %b want %h", d, got, e); end
  endtask

  task automatic test_conflict();
    int fills; bit got, bad; word_t d, e;
    sb.push_back(mem_word(32'h440));
    fetch(32'h440, 1, fills, got, d, bad);
    checks++; if (fills !== 2 || bad) begin errors++; $display("FAIL conflict_fill got %0d want 2", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL conflict_data got %h want %h", d, e); end
    sb.push_back(mem_word(32'h40));
    fetch(32'h40, 0, fills, got, d, bad);
    checks++; if (fills !== 1) begin errors++; $display("FAIL conflict_evict got %0d want 1", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL conflict_refill got %h want %h", d, e); end
  endtask

  task automatic test_redirect();
    int fills; bit got, bad; word_t d, e;
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1; imemaddr = 32'h104;
    @(negedge CLK);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h80) begin
      errors++; $display("FAIL redirect_fill_addr got %b/%h want 1/00000080", iREN, iaddr);
    end
    iwait = 1'b0; iload = mem_word(32'h80);
    @(posedge CLK); #1; iwait = 1'b1;
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      errors++; $display("FAIL redirect_idle_miss got hit %b iREN %b want 0 0", ihit, iREN);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h104) begin
      errors++; $display("FAIL redirect_new_fill got %b/%h want 1/00000104", iREN, iaddr);
    end
    iwait = 1'b0; iload = mem_word(32'h104); sb.push_back(mem_word(32'h104));
    @(posedge CLK); #1; iwait = 1'b1;
    @(negedge CLK);
    e = sb.pop_front();
    checks++;
    if (ihit !== 1'b1 || imemload !== e) begin
      errors++; $display("FAIL redirect_new_hit got %b/%h want 1/%h", ihit, imemload, e);
    end
    @(posedge CLK); #1; imemREN = 1'b0;
    sb.push_back(mem_word(32'h80));
    fetch(32'h80, 0, fills, got, d, bad);
    checks++; if (fills !== 0) begin errors++; $display("FAIL redirect_old_kept got %0d fills want 0", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL redirect_old_data got %h want %h", d, e); end
  endtask

  task automatic test_invalidate();
    int fills; bit got, bad; word_t d, e;
    sb.push_back(mem_word(32'h40));
    fetch(32'h40, 0, fills, got, d, bad);
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL inval_prep got %h want %h", d, e); end
    imemREN = 1'b1; imemaddr = 32'h40; iinval = 1'b1;
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL inval_forces_miss got %b want 0", ihit); end
    @(posedge CLK); #1; iinval = 1'b0; imemREN = 1'b0;
    sb.push_back(mem_word(32'h40));
    fetch(32'h40, 0, fills, got, d, bad);
    checks++; if (fills !== 1) begin errors++; $display("FAIL inval_cleared got %0d fills want 1", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL inval_refill got %h want %h", d, e); end
    imemREN = 1'b1; imemaddr = 32'h208; iwait = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL inval_fill_start got %b want 1", iREN); end
    iwait = 1'b0; iload = mem_word(32'h208); iinval = 1'b1;
    @(posedge CLK); #1; iwait = 1'b1; iinval = 1'b0; imemREN = 1'b0;
    sb.push_back(mem_word(32'h208));
    fetch(32'h208, 0, fills, got, d, bad);
    checks++; if (fills !== 1) begin errors++; $display("FAIL inval_fill_dropped got %0d fills want 1", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL inval_fill_data got %h want %h", d, e); end
  endtask

  task automatic test_reset_mid_fill();
    int fills; bit got, bad; word_t d, e;
    sb.push_back(mem_word(32'h80));
    fetch(32'h80, 0, fills, got, d, bad);
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL rst_prep got %h want %h", d, e); end
    imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL rst_in_fill got %b want 1", iREN); end
    #1; nRST = 1'b0; #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
      errors++; $display("FAIL rst_async got iREN %b iaddr %h ihit %b want 0 0 0", iREN, iaddr, ihit);
    end
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++; $display("FAIL rst_counters got %h/%h want 0/0", hit_count, miss_count);
    end
`endif
    @(posedge CLK); #1;
    @(negedge CLK); nRST = 1'b1; imemREN = 1'b0;
    @(posedge CLK); #1;
    sb.push_back(mem_word(32'h80));
    fetch(32'h80, 0, fills, got, d, bad);
    checks++; if (fills !== 1) begin errors++; $display("FAIL rst_cleared got %0d fills want 1", fills); end
    e = sb.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL rst_refill got %h want %h", d, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_redirect();
    test_invalidate();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
